// File: rtl/grant_scheduler.sv
// grant_scheduler: four-way round-robin arbiter for one shared resource.
// Produces a registered one-hot grant plus the matching 2-to-4 decoder
// address/enable, and revokes a contended grant after MAX_HOLD cycles.
module grant_scheduler #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_addr,
  output logic       grant_en,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  logic [1:0]         ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [1:0]         win;
  logic [1:0]         idx;
  logic               found;
  logic               others;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  // Winner search: first requester at or after ptr, wrapping mod 4.
  always_comb begin
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Contention: some requester other than the current owner is waiting.
  always_comb begin
    others = |(req & ~(4'b0001 << grant_addr));
  end

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      grant      <= '0;
      grant_addr <= '0;
      grant_en   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_addr <= win;
            grant_en   <= 1'b1;
            grant      <= 4'b0001 << win;
            hold_cnt   <= CNT_W'(1);
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (!req[grant_addr]) begin
            // Release takes precedence over the hold limit, so no timeout.
            grant_en <= 1'b0;
            grant    <= '0;
            ptr      <= grant_addr + 2'd1;
            hold_cnt <= '0;
            state    <= IDLE;
          end else if (hold_cnt == HOLD_LIMIT && others) begin
            grant_en <= 1'b0;
            grant    <= '0;
            timeout  <= 1'b1;
            ptr      <= grant_addr + 2'd1;
            hold_cnt <= '0;
            state    <= IDLE;
          end else if (hold_cnt < HOLD_LIMIT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/grant_scheduler.md
# grant_scheduler

Four-way round-robin scheduler that shares one resource among four requesters and drives the address/enable inputs of the 2-to-4 decoder. The registered grant output equals the one-hot decode of that address and enable. The block sits between the requesters and the shared resource. It holds a grant while the owner keeps requesting, and forcibly rotates ownership after a bounded hold time when other requesters are waiting.

## Interface
- MAX_HOLD, 8: maximum contended hold time in cycles; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  level request; req[i] is requester i. It stays high for as long as requester i wants the resource.
- grant  output  4  registered one-hot grant, at most one bit set.
- grant_addr  output  2  index of the current or last owner; this is the decoder address {address1,address0}.
- grant_en  output  1  decoder enable; high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Internal state: fsm in {IDLE, GRANT}, 2-bit priority pointer ptr, hold counter hold_cnt[CNT_W-1:0], owner w (equal to grant_addr).
- Invariant on every cycle: grant == ({3'b0,grant_en} << grant_addr).
- Search order from ptr: ptr, ptr+1, ptr+2, ptr+3, all mod 4 (3 wraps to 0). The winner is the first index with req set.
- IDLE, any req set:
  - grant_addr <= winner, grant_en <= 1, hold_cnt <= 1, state goes to GRANT.
- IDLE, no req set:
  - Outputs hold, grant_en stays 0, grant_addr keeps its last value.
- GRANT, req[w] == 0 (release):
  - grant_en <= 0, ptr <= w+1, hold_cnt <= 0, state goes to IDLE. timeout stays 0.
- GRANT, req[w] == 1, hold_cnt == MAX_HOLD, and any req[j] set with j != w (revoke):
  - grant_en <= 0, timeout <= 1, ptr <= w+1, hold_cnt <= 0, state goes to IDLE.
- GRANT, otherwise:
  - Grant holds. hold_cnt <= hold_cnt+1, saturating at MAX_HOLD.
  - An uncontended owner keeps the grant indefinitely.
- timeout is high for exactly one cycle after a revoke and is 0 at all other times.
- Release and hold limit in the same cycle: release wins and timeout stays 0.
- A revoked requester that keeps req high is treated as a new request and gets no special priority.
- Requests that rise while the block is in GRANT are only considered at the next IDLE arbitration.
- Reset (asynchronous, any state): grant=0, grant_addr=0, grant_en=0, timeout=0, ptr=0, hold_cnt=0, fsm=IDLE.
  - Outputs clear immediately on reset_n falling, not at the next clock edge.
  - The first arbitration happens at the first rising edge after reset_n rises.

## Timing
- Request to grant: req sampled high at edge k while in IDLE gives grant high after edge k (1 cycle).
- Release to drop: req[w] sampled low at edge k gives grant low after edge k.
- Turnaround: every grant is followed by at least one idle cycle (grant_en low). The earliest next grant is after edge k+1.
- Contended hold: grant_en is high for exactly MAX_HOLD cycles. timeout is high in the first cycle after the grant drops.
- Steady contention from all four requesters: each period is MAX_HOLD grant cycles plus 1 idle cycle, and ownership rotates 0,1,2,3,0.
- No combinational path from req to any output; every output comes straight from a register.

## Test plan
Bench parameter MAX_HOLD=4.
- Reset: hold reset_n=0 with req=4'b1111 -> all outputs 0. Release reset -> after the first edge, grant=0001, grant_addr=0, grant_en=1.
- Single requester: req=0100 held for 10 cycles, then 0000 -> grant=0100 for 10 cycles, timeout never asserts. After the drop, grant=0000 and ptr=3.
- Round-robin wrap: req=1111 held for 25 cycles -> grants go 0001,0010,0100,1000,0001. Each lasts 4 cycles, followed by 1 idle cycle with timeout=1.
- Release/limit tie: owner 2 with req=0101; drop req[2] in the cycle where hold_cnt==4 -> timeout stays 0, and the next grant is 0001.
- Pointer skip: ptr=1 after owner 0 releases; req=1001 -> the next grant is 1000 (index 3), not 0001.
- Mid-grant reset: pull reset_n low during a grant to 0010 -> grant=0000 and grant_en=0 before the next clock edge. After reset releases with req=0010, the grant is 0010 with hold_cnt restarting at 1.
